// File: rtl/regfile_bank16.sv
// regfile_bank16: 16-entry register bank fed by a one-hot write-enable decoder.
//   Stores operands / partial results for the factorization engine, exposes
//   two registered read ports with per-register valid bits, flags illegal
//   multi-hot enables (sticky ERR) and counts accepted writes (saturating).
//
// Parameters:
//   W      data width of each register and of WD/RD1/RD2
//   CNT_W  width of the saturating accepted-write counter WCOUNT
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   EN      in   16-bit one-hot write enable (0 = no write, >1 bit = illegal)
//   WD      in   write data
//   CLR     in   clear all valid bits and WCOUNT (data kept)
//   RA1/RA2 in   read addresses
//   RD1/RD2 out  registered read data
//   RV1/RV2 out  registered valid bit of the addressed register
//   ERR     out  sticky illegal-enable flag (cleared only by reset)
//   WCOUNT  out  accepted-write count, saturating at 2^CNT_W-1
//
// Optional feature macro: READ_BYPASS_EN
//   When defined, a legal write to the address on a read port in the same
//   cycle is forwarded to that port (RD <= WD, RV <= 1).

module regfile_bank16 #(
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      EN,
  input  logic [W-1:0]     WD,
  input  logic             CLR,
  input  logic [3:0]       RA1,
  input  logic [3:0]       RA2,
  output logic [W-1:0]     RD1,
  output logic [W-1:0]     RD2,
  output logic             RV1,
  output logic             RV2,
  output logic             ERR,
  output logic [CNT_W-1:0] WCOUNT
);

  localparam int unsigned     NREG    = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [W-1:0]     r_mem [NREG];
  logic [NREG-1:0]  r_valid;
  logic [W-1:0]     r_rd1;
  logic [W-1:0]     r_rd2;
  logic             r_rv1;
  logic             r_rv2;
  logic             r_err;
  logic [CNT_W-1:0] r_wcount;

  logic             w_en_any;
  logic             w_en_multi;
  logic             w_legal;
  logic             w_illegal;
  logic [NREG-1:0]  w_valid_nxt;
  logic [CNT_W-1:0] w_wcount_nxt;

  // Enable classification: clearing the lowest set bit leaves a nonzero value
  // only when two or more bits are set.
  always_comb begin
    w_en_any   = |EN;
    w_en_multi = |(EN & (EN - 16'd1));
    w_legal    = w_en_any & ~w_en_multi;
    w_illegal  = w_en_multi;
  end

  // Next valid vector: CLR wipes everything, a legal write then re-marks its
  // own register so CLR+write leaves exactly that register valid.
  always_comb begin
    w_valid_nxt = CLR ? '0 : r_valid;
    if (w_legal) begin
      w_valid_nxt = w_valid_nxt | EN;
    end
  end

  // Next write count: CLR restarts from zero before counting this cycle's write.
  always_comb begin
    w_wcount_nxt = CLR ? '0 : r_wcount;
    if (w_legal && (w_wcount_nxt != CNT_MAX)) begin
      w_wcount_nxt = w_wcount_nxt + CNT_W'(1);
    end
  end

  // Register storage; only a legal one-hot enable writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_legal) begin
      for (int i = 0; i < NREG; i++) begin
        if (EN[i]) begin
          r_mem[i] <= WD;
        end
      end
    end
  end

  // Valid bits, write counter and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_wcount <= '0;
      r_err    <= 1'b0;
    end else begin
      r_valid  <= w_valid_nxt;
      r_wcount <= w_wcount_nxt;
      if (w_illegal) begin
        r_err <= 1'b1;
      end
    end
  end

  // Read ports sample pre-edge state unless bypass forwards a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd1 <= '0;
      r_rd2 <= '0;
      r_rv1 <= 1'b0;
      r_rv2 <= 1'b0;
    end else begin
`ifdef READ_BYPASS_EN
      if (w_legal && EN[RA1]) begin
        r_rd1 <= WD;
        r_rv1 <= 1'b1;
      end else begin
        r_rd1 <= r_mem[RA1];
        r_rv1 <= r_valid[RA1];
      end
      if (w_legal && EN[RA2]) begin
        r_rd2 <= WD;
        r_rv2 <= 1'b1;
      end else begin
        r_rd2 <= r_mem[RA2];
        r_rv2 <= r_valid[RA2];
      end
`else
      r_rd1 <= r_mem[RA1];
      r_rv1 <= r_valid[RA1];
      r_rd2 <= r_mem[RA2];
      r_rv2 <= r_valid[RA2];
`endif
    end
  end

  assign RD1    = r_rd1;
  assign RD2    = r_rd2;
  assign RV1    = r_rv1;
  assign RV2    = r_rv2;
  assign ERR    = r_err;
  assign WCOUNT = r_wcount;

endmodule

// File: tb/tb_regfile_bank16.sv
// Self-checking bench for regfile_bank16: directed scenarios plus randomized
// traffic, every cycle compared against an array-based reference model.

module tb_regfile_bank16;

  localparam int unsigned W     = 16;
  localparam int unsigned CNT_W = 8;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic [15:0]      EN;
  logic [W-1:0]     WD;
  logic             CLR;
  logic [3:0]       RA1;
  logic [3:0]       RA2;
  logic [W-1:0]     RD1;
  logic [W-1:0]     RD2;
  logic             RV1;
  logic             RV2;
  logic             ERR;
  logic [CNT_W-1:0] WCOUNT;

  regfile_bank16 #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .WD(WD), .CLR(CLR),
    .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2), .RV1(RV1), .RV2(RV2),
    .ERR(ERR), .WCOUNT(WCOUNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] m_mem [16];
  bit           m_val [16];
  bit           m_err;
  int           m_cnt;
  logic [W-1:0] e_rd1, e_rd2;
  bit           e_rv1, e_rv2;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare all outputs.
  task automatic cyc(input logic rn, input logic [15:0] en, input logic [W-1:0] wd,
                     input logic clr, input logic [3:0] a1, input logic [3:0] a2);
    int ones;
    int idx;
    rst_n = rn; EN = en; WD = wd; CLR = clr; RA1 = a1; RA2 = a2;
    @(posedge clk);
    #1;
    ones = $countones(en);
    idx  = -1;
    for (int i = 0; i < 16; i++) if (en[i]) idx = i;
    if (!rn) begin
      for (int i = 0; i < 16; i++) begin m_mem[i] = '0; m_val[i] = 0; end
      m_err = 0; m_cnt = 0;
      e_rd1 = '0; e_rd2 = '0; e_rv1 = 0; e_rv2 = 0;
    end else begin
      e_rd1 = m_mem[a1]; e_rv1 = m_val[a1];
      e_rd2 = m_mem[a2]; e_rv2 = m_val[a2];
`ifdef READ_BYPASS_EN
      if (ones == 1 && idx == int'(a1)) begin e_rd1 = wd; e_rv1 = 1; end
      if (ones == 1 && idx == int'(a2)) begin e_rd2 = wd; e_rv2 = 1; end
`endif
      if (clr) begin
        for (int i = 0; i < 16; i++) m_val[i] = 0;
        m_cnt = 0;
      end
      if (ones == 1) begin
        m_mem[idx] = wd;
        m_val[idx] = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
      if (ones > 1) m_err = 1;
    end
    check("RD1", 32'(RD1), 32'(e_rd1));
    check("RD2", 32'(RD2), 32'(e_rd2));
    check("RV1", 32'(RV1), 32'(e_rv1));
    check("RV2", 32'(RV2), 32'(e_rv2));
    check("ERR", 32'(ERR), 32'(m_err));
    check("WCOUNT", 32'(WCOUNT), 32'(m_cnt));
  endtask

  function automatic logic [15:0] rand_en();
    int r;
    logic [15:0] v;
    r = $urandom_range(99, 0);
    if (r < 20) return 16'h0000;
    if (r < 80) return 16'(1) << $urandom_range(15, 0);
    v = 16'($urandom());
    while ($countones(v) < 2) v = 16'($urandom());
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; EN = '0; WD = '0; CLR = 1'b0; RA1 = '0; RA2 = '0;

    // Reset then read
    cyc(0, 16'h0, 16'h0, 0, 4'd0, 4'd0);
    cyc(0, 16'h0, 16'h0, 0, 4'd0, 4'd0);
    cyc(1, 16'h0, 16'h0, 0, 4'd3, 4'd15);
    check("reset_rd1", 32'(RD1), 32'h0);
    check("reset_rv2", 32'(RV2), 32'h0);
    check("reset_wcount", 32'(WCOUNT), 32'h0);

    // Write reg 5 and read back
    cyc(1, 16'h0020, 16'hBEEF, 0, 4'd0, 4'd0);
    cyc(1, 16'h0000, 16'h0, 0, 4'd5, 4'd5);
    check("wr5_rd1", 32'(RD1), 32'hBEEF);
    check("wr5_rv1", 32'(RV1), 32'h1);
    check("wr5_wcount", 32'(WCOUNT), 32'h1);

    // Illegal enable: nothing written, ERR sticky through CLR, reset clears it
    cyc(1, 16'h0011, 16'h1234, 0, 4'd0, 4'd4);
    cyc(1, 16'h0000, 16'h0, 0, 4'd0, 4'd4);
    check("illegal_err", 32'(ERR), 32'h1);
    check("illegal_rv_reg0", 32'(RV1), 32'h0);
    check("illegal_rv_reg4", 32'(RV2), 32'h0);
    check("illegal_wcount", 32'(WCOUNT), 32'h1);
    cyc(1, 16'h0000, 16'h0, 1, 4'd5, 4'd5);
    cyc(1, 16'h0000, 16'h0, 0, 4'd5, 4'd5);
    check("clr_keeps_err", 32'(ERR), 32'h1);
    check("clr_drops_valid", 32'(RV1), 32'h0);
    check("clr_keeps_data", 32'(RD1), 32'hBEEF);
    cyc(0, 16'h0000, 16'h0, 0, 4'd0, 4'd0);
    check("reset_clears_err", 32'(ERR), 32'h0);

    // CLR together with a legal write
    cyc(1, 16'h0002, 16'h0055, 0, 4'd0, 4'd0);
    cyc(1, 16'h0004, 16'h0066, 0, 4'd0, 4'd0);
    cyc(1, 16'h0004, 16'h00AA, 1, 4'd0, 4'd0);
    cyc(1, 16'h0000, 16'h0, 0, 4'd1, 4'd2);
    check("clrwr_rv_reg1", 32'(RV1), 32'h0);
    check("clrwr_rd_reg2", 32'(RD2), 32'h00AA);
    check("clrwr_rv_reg2", 32'(RV2), 32'h1);
    check("clrwr_wcount", 32'(WCOUNT), 32'h1);

    // Same-cycle read/write on address 7
    cyc(1, 16'h0080, 16'h0011, 0, 4'd0, 4'd0);
    cyc(1, 16'h0080, 16'h0022, 0, 4'd7, 4'd7);
`ifdef READ_BYPASS_EN
    check("rw7_same_cycle", 32'(RD1), 32'h0022);
    check("rw7_same_rv", 32'(RV1), 32'h1);
`else
    check("rw7_same_cycle", 32'(RD1), 32'h0011);
`endif
    cyc(1, 16'h0000, 16'h0, 0, 4'd7, 4'd7);
    check("rw7_next", 32'(RD1), 32'h0022);

    // Counter saturation with 300 random legal writes
    cyc(1, 16'h0000, 16'h0, 1, 4'd0, 4'd0);
    for (int k = 0; k < 300; k++)
      cyc(1, 16'(1) << $urandom_range(15, 0), 16'($urandom()), 0,
          4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
    check("sat_wcount", 32'(WCOUNT), 32'd255);
    cyc(1, 16'h0000, 16'h0, 1, 4'd0, 4'd0);
    check("sat_clr", 32'(WCOUNT), 32'd0);

    // Randomized traffic including CLR, illegal enables and mid-run resets
    for (int k = 0; k < 600; k++)
      cyc(($urandom_range(99, 0) < 2) ? 1'b0 : 1'b1, rand_en(), 16'($urandom()),
          ($urandom_range(99, 0) < 8) ? 1'b1 : 1'b0,
          4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
